// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one 64-bit load/store at a time, waits
// LATENCY cycles, accesses a doubleword array and holds the response until consumed.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic [63:0] mem [DEPTH];

  logic          addr_err;
  logic [IW-1:0] idx;
  logic          access;
  logic          mem_we;

  // Range check uses all 61 index bits so huge addresses never alias low words.
  assign addr_err = (addr_q[2:0] != 3'b000) || (addr_q[63:3] >= 61'(DEPTH));
  assign idx      = addr_q[3 +: IW];
  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we   = access && write_q && !addr_err;

  // Array has no reset so it maps onto block RAM and survives resetl.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            err_q   <= addr_err;
            rdata_q <= (!addr_err && !write_q) ? mem[idx] : 64'd0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, corner sequences,
// a LATENCY=1 throughput run and randomized traffic against an array model.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        req_valid, req_write, rsp_ready;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;

  logic        req_valid1, req_write1, rsp_ready1;
  logic [63:0] req_addr1, req_wdata1;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [63:0] rsp_rdata1;

  int n_pass  = 0;
  int n_total = 0;

  bit [63:0] ref_mem [int];

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .CLK(CLK), .resetl(resetl),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .CLK(CLK), .resetl(resetl),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic bit model_err(input logic [63:0] a);
    return (a % 8 != 0) || (a / 8 >= 64);
  endfunction

  // One complete transaction on the LATENCY=2 instance, bp cycles of backpressure.
  task automatic do_txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input int bp, output logic [63:0] rd, output logic er);
    int n;
    int lat;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge CLK); n++; end
    check("req_ready before issue", req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge CLK);
    req_valid = 0; req_write = 1'($urandom); req_addr = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(negedge CLK); lat++; end
    check("latency", 64'(lat), 64'd2);
    rd = rsp_rdata; er = rsp_err;
    for (int i = 0; i < bp; i++) begin
      @(negedge CLK);
      check("bp rsp_valid held", rsp_valid, 1);
      check("bp rdata stable", rsp_rdata, rd);
    end
    rsp_ready = 1;
    @(negedge CLK);
    rsp_ready = 0;
    check("rsp_valid drop", rsp_valid, 0);
    check("req_ready return", req_ready, 1);
    if (w && !model_err(a)) ref_mem[int'(a / 8)] = d;
    $display("txn %s addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d", w ? "ST" : "LD", a, d, rd, er, lat);
  endtask

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [63:0] rd, dead, tp_data [4], a, d;
    logic er, w;
    int acc [8];
    int k, nrsp, cyc, r, idx;

    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0; rsp_ready1 = 0;
    resetl = 0;
    #2;
    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_rdata", rsp_rdata, 0);
    check("reset rsp_err", rsp_err, 0);
    @(negedge CLK);
    resetl = 1;
    repeat (3) begin
      @(negedge CLK);
      check("idle req_ready", req_ready, 1);
      check("idle rsp_valid", rsp_valid, 0);
    end

    // Store then load, LATENCY=2.
    dead = 64'hDEADBEEFCAFEF00D;
    do_txn(1, 64'h10, dead, 0, rd, er);
    check("store err", er, 0);
    check("store rdata", rd, 0);
    do_txn(0, 64'h10, 0, 0, rd, er);
    check("load err", er, 0);
    check("load rdata", rd, dead);

    // Backpressure with an ignored request pulse in the middle.
    req_valid = 1; req_write = 0; req_addr = 64'h10;
    @(negedge CLK);
    req_valid = 0;
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin @(negedge CLK); cyc++; end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin req_valid = 1; req_write = 1; req_addr = 64'h10; req_wdata = 64'h5555; end
      if (i == 3) req_valid = 0;
      check("bp rsp_valid", rsp_valid, 1);
      check("bp rsp_rdata", rsp_rdata, dead);
      check("bp req_ready low", req_ready, 0);
      @(negedge CLK);
    end
    rsp_ready = 1;
    @(negedge CLK);
    rsp_ready = 0;
    check("bp release rsp_valid", rsp_valid, 0);
    check("bp release req_ready", req_ready, 1);
    do_txn(0, 64'h10, 0, 0, rd, er);
    check("bp pulse ignored", rd, dead);

    // Error table: misaligned, out of range, and aliasing probes.
    vecs[0]  = '{1, 64'h1F8, 64'hA1A1A1A1A1A1A1A1, 0, 0};
    vecs[1]  = '{1, 64'h0,   64'hC0C0C0C0C0C0C0C0, 0, 0};
    vecs[2]  = '{0, 64'h13,  0, 1, 0};
    vecs[3]  = '{1, 64'h200, 64'hBBBBBBBBBBBBBBBB, 1, 0};
    vecs[4]  = '{0, 64'h1F8, 0, 0, 64'hA1A1A1A1A1A1A1A1};
    vecs[5]  = '{0, 64'h0,   0, 0, 64'hC0C0C0C0C0C0C0C0};
    vecs[6]  = '{1, 64'h8000000000000000, 64'h9999, 1, 0};
    vecs[7]  = '{0, 64'h0,   0, 0, 64'hC0C0C0C0C0C0C0C0};
    vecs[8]  = '{0, 64'h1F9, 0, 1, 0};
    vecs[9]  = '{1, 64'h1FC, 64'h7777, 1, 0};
    vecs[10] = '{0, 64'h1F8, 0, 0, 64'hA1A1A1A1A1A1A1A1};
    vecs[11] = '{0, 64'h200, 0, 1, 0};
    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].w, vecs[i].a, vecs[i].d, i % 3, rd, er);
      check($sformatf("vec%0d err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
    end

    // Asynchronous reset while a response is pending.
    req_valid = 1; req_write = 0; req_addr = 64'h10;
    @(negedge CLK);
    req_valid = 0;
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin @(negedge CLK); cyc++; end
    check("resp before reset", rsp_valid, 1);
    #2 resetl = 0;
    #1;
    check("async rst req_ready", req_ready, 1);
    check("async rst rsp_valid", rsp_valid, 0);
    check("async rst rsp_rdata", rsp_rdata, 0);
    check("async rst rsp_err", rsp_err, 0);
    @(negedge CLK);
    resetl = 1;

    // Reset during BUSY discards the pending store.
    do_txn(1, 64'h8, 64'h2222, 0, rd, er);
    check("st 0x8 err", er, 0);
    req_valid = 1; req_write = 1; req_addr = 64'h8; req_wdata = 64'h1111;
    @(negedge CLK);
    req_valid = 0;
    #2 resetl = 0;
    repeat (3) begin
      @(negedge CLK);
      check("busy rst no rsp", rsp_valid, 0);
    end
    resetl = 1;
    do_txn(0, 64'h8, 0, 0, rd, er);
    check("busy rst store dropped", rd, 64'h2222);

    // Throughput on the LATENCY=1 instance.
    for (int i = 0; i < 4; i++) tp_data[i] = {$urandom, $urandom};
    rsp_ready1 = 1;
    k = 0; nrsp = 0; cyc = 0;
    while ((k < 8 || nrsp < 8) && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (rsp_valid1) begin
        check($sformatf("tp rsp%0d err", nrsp), rsp_err1, 0);
        if (nrsp < 8)
          check($sformatf("tp rsp%0d rdata", nrsp), rsp_rdata1, nrsp < 4 ? 64'd0 : tp_data[nrsp - 4]);
        $display("tp rsp %0d rdata=%h cyc=%0d", nrsp, rsp_rdata1, cyc);
        nrsp++;
      end
      if (req_ready1) begin
        if (k < 8) begin
          acc[k] = cyc;
          req_valid1 = 1;
          req_write1 = (k < 4);
          req_addr1  = 64'(8 * (k % 4));
          req_wdata1 = (k < 4) ? tp_data[k] : 64'd0;
          k++;
        end else begin
          req_valid1 = 0;
        end
      end
    end
    req_valid1 = 0;
    check("tp accepts", 64'(k), 64'd8);
    check("tp responses", 64'(nrsp), 64'd8);
    for (int i = 1; i < 8; i++) check($sformatf("tp spacing%0d", i), 64'(acc[i] - acc[i-1]), 64'd3);

    // Randomized traffic against the array model.
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      idx = $urandom_range(0, 63);
      if (r < 7)       a = 64'(idx * 8);
      else if (r == 7) a = 64'(idx * 8 + $urandom_range(1, 7));
      else if (r == 8) a = {$urandom, $urandom} | 64'h200;
      else             a = ($urandom_range(0, 1) != 0) ? 64'h200 : 64'h1F8;
      w = 1'($urandom);
      d = {$urandom, $urandom};
      do_txn(w, a, d, $urandom_range(0, 3), rd, er);
      check($sformatf("rnd%0d err", t), er, model_err(a));
      if (w || model_err(a))
        check($sformatf("rnd%0d rdata zero", t), rd, 0);
      else if (ref_mem.exists(int'(a / 8)))
        check($sformatf("rnd%0d rdata", t), rd, ref_mem[int'(a / 8)]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
